// File: rtl/hyp_s2_pkg.sv
// Shared types and fixed shift-term tables for the stage-2 hyperbolic rotation.
// The tables are only valid for FRAC = 12.
package hyp_s2_pkg;

    localparam int NTERMS       = 4;
    localparam int FRAC_DEFAULT = 12;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        A0125  = 2'd1,
        A025   = 2'd2,
        A05    = 2'd3
    } mode_e;

    // Each row is {term3, term2, term1, term0}; every term is a right-shift amount.
    typedef logic [NTERMS-1:0][3:0] shift_row_t;
    typedef logic [NTERMS-1:0]      mask_t;

    localparam shift_row_t C_SHIFT [4] = '{
        {4'd0, 4'd0,  4'd0, 4'd0},
        {4'd0, 4'd0,  4'd7, 4'd0},
        {4'd0, 4'd13, 4'd5, 4'd0},
        {4'd0, 4'd9,  4'd3, 4'd0}
    };
    localparam mask_t C_MASK [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b0111};

    localparam shift_row_t S_SHIFT [4] = '{
        {4'd0,  4'd0,  4'd0,  4'd0},
        {4'd0,  4'd0,  4'd12, 4'd3},
        {4'd0,  4'd11, 4'd9,  4'd2},
        {4'd10, 4'd8,  4'd6,  4'd1}
    };
    localparam mask_t S_MASK [4] = '{4'b0000, 4'b0011, 4'b0111, 4'b1111};

endpackage

// File: rtl/hyp_shift_sum.sv
// Multiplier-free coefficient product: sums up to NTERMS arithmetic-shifted copies
// of one operand, selecting the cosh or sinh term table for the given mode.
module hyp_shift_sum
    import hyp_s2_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter bit IS_SINH = 1'b0
) (
    input  logic signed [DWIDTH-1:0] operand,
    input  mode_e                    mode,
    output logic signed [DWIDTH+1:0] sum
);

    shift_row_t               shifts_s;
    mask_t                    mask_s;
    logic signed [DWIDTH+1:0] ext_s;

    // Table lookup and sign extension of the operand
    always_comb begin
        if (IS_SINH) begin
            shifts_s = S_SHIFT[mode];
            mask_s   = S_MASK[mode];
        end else begin
            shifts_s = C_SHIFT[mode];
            mask_s   = C_MASK[mode];
        end
        ext_s = {{2{operand[DWIDTH-1]}}, operand};
    end

    // Each term is truncated on its own before summing
    always_comb begin
        sum = {(DWIDTH+2){1'b0}};
        for (int i = 0; i < NTERMS; i++) begin
            if (mask_s[i]) begin
                sum = sum + (ext_s >>> shifts_s[i]);
            end else begin
                sum = sum;
            end
        end
    end

endmodule

// File: rtl/s2_hyp_rotate_pipe.sv
// Three-stage valid/ready pipeline applying a fixed-angle hyperbolic rotation
// to (x, y): S1 captures operands, S2 registers the four shift-sum products, S3 combines and clips.
module s2_hyp_rotate_pipe
    import hyp_s2_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int FRAC   = 12,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iValid,
    output logic              iReady,
    input  logic [DWIDTH-1:0] iX,
    input  logic [DWIDTH-1:0] iY,
    input  logic [1:0]        iMode,
    input  logic              iDir,
    output logic              oValid,
    input  logic              oReady,
    output logic [DWIDTH-1:0] oX,
    output logic [DWIDTH-1:0] oY,
    output logic              oSat
);

    localparam int SW = DWIDTH + 2;
    localparam int RW = DWIDTH + 3;
    localparam logic signed [RW-1:0] MAXV = {{4{1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{4{1'b1}}, {(DWIDTH-1){1'b0}}};

    if (FRAC != FRAC_DEFAULT) begin : g_frac_check
        $error("s2_hyp_rotate_pipe: coefficient tables only support FRAC = 12");
    end

    // Returns {clipped, value}; clipping only happens when saturation is enabled
    function automatic logic [DWIDTH:0] clip_fn(input logic signed [RW-1:0] v);
        if ((SAT_EN != 32'sd0) && (v > MAXV)) begin
            clip_fn = {1'b1, 1'b0, {(DWIDTH-1){1'b1}}};
        end else if ((SAT_EN != 32'sd0) && (v < MINV)) begin
            clip_fn = {1'b1, 1'b1, {(DWIDTH-1){1'b0}}};
        end else begin
            clip_fn = {1'b0, v[DWIDTH-1:0]};
        end
    endfunction

    logic                     ld1_s, ld2_s, ld3_s;
    logic                     v1_r, v2_r;
    logic signed [DWIDTH-1:0] x1_r, y1_r;
    mode_e                    mode1_r;
    logic                     dir1_r, dir2_r;
    logic signed [SW-1:0]     cx_s, cy_s, sx_s, sy_s;
    logic signed [SW-1:0]     cx2_r, cy2_r, sx2_r, sy2_r;
    logic signed [RW-1:0]     cxe_s, cye_s, sxe_s, sye_s, xw_s, yw_s;
    logic [DWIDTH:0]          xclip_s, yclip_s;

    // A stage may load when it is empty or its successor is loading
    assign ld3_s  = !oValid || oReady;
    assign ld2_s  = !v2_r || ld3_s;
    assign ld1_s  = !v1_r || ld2_s;
    assign iReady = ld1_s;

    // S1: capture operands and per-sample mode/direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            x1_r    <= {DWIDTH{1'b0}};
            y1_r    <= {DWIDTH{1'b0}};
            mode1_r <= BYPASS;
            dir1_r  <= 1'b0;
        end else if (ld1_s) begin
            v1_r <= iValid;
            if (iValid) begin
                x1_r    <= iX;
                y1_r    <= iY;
                mode1_r <= mode_e'(iMode);
                dir1_r  <= iDir;
            end
        end
    end

    hyp_shift_sum #(.DWIDTH(DWIDTH), .IS_SINH(1'b0)) u_cx (.operand(x1_r), .mode(mode1_r), .sum(cx_s));
    hyp_shift_sum #(.DWIDTH(DWIDTH), .IS_SINH(1'b0)) u_cy (.operand(y1_r), .mode(mode1_r), .sum(cy_s));
    hyp_shift_sum #(.DWIDTH(DWIDTH), .IS_SINH(1'b1)) u_sx (.operand(x1_r), .mode(mode1_r), .sum(sx_s));
    hyp_shift_sum #(.DWIDTH(DWIDTH), .IS_SINH(1'b1)) u_sy (.operand(y1_r), .mode(mode1_r), .sum(sy_s));

    // S2: register the four partial products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r   <= 1'b0;
            cx2_r  <= {SW{1'b0}};
            cy2_r  <= {SW{1'b0}};
            sx2_r  <= {SW{1'b0}};
            sy2_r  <= {SW{1'b0}};
            dir2_r <= 1'b0;
        end else if (ld2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                cx2_r  <= cx_s;
                cy2_r  <= cy_s;
                sx2_r  <= sx_s;
                sy2_r  <= sy_s;
                dir2_r <= dir1_r;
            end
        end
    end

    // S3 datapath: cross-combine products and clip to the output range
    always_comb begin
        cxe_s = RW'(cx2_r);
        cye_s = RW'(cy2_r);
        sxe_s = RW'(sx2_r);
        sye_s = RW'(sy2_r);
        if (dir2_r) begin
            xw_s = cxe_s - sye_s;
            yw_s = cye_s - sxe_s;
        end else begin
            xw_s = cxe_s + sye_s;
            yw_s = cye_s + sxe_s;
        end
        xclip_s = clip_fn(xw_s);
        yclip_s = clip_fn(yw_s);
    end

    // S3: registered outputs, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oValid <= 1'b0;
            oX     <= {DWIDTH{1'b0}};
            oY     <= {DWIDTH{1'b0}};
            oSat   <= 1'b0;
        end else if (ld3_s) begin
            oValid <= v2_r;
            if (v2_r) begin
                oX   <= xclip_s[DWIDTH-1:0];
                oY   <= yclip_s[DWIDTH-1:0];
                oSat <= xclip_s[DWIDTH] | yclip_s[DWIDTH];
            end
        end
    end

endmodule

// File: tb/tb_s2_hyp_rotate_pipe.sv
// Bench for s2_hyp_rotate_pipe: a saturating and a wrapping instance share the
// same stimulus and are compared against a plain-arithmetic rotation model.
module tb_s2_hyp_rotate_pipe;

    logic        clk;
    logic        rst_n;
    logic        iValid, oReady, iDir;
    logic [15:0] iX, iY;
    logic [1:0]  iMode;
    logic        iReady, oValid, oSat;
    logic [15:0] oX, oY;
    logic        iReady_w, oValid_w, oSat_w;
    logic [15:0] oX_w, oY_w;

    int total = 0;
    int bad   = 0;

    logic [32:0] q1[$];
    logic [32:0] q0[$];
    logic        hold_pend = 1'b0;
    logic [15:0] hold_x, hold_y;
    logic        hold_s;

    // Shift amounts per angle; -1 marks an unused slot
    int C_TAB [4][4] = '{'{0, -1, -1, -1}, '{0, 7, -1, -1}, '{0, 5, 13, -1}, '{0, 3, 9, -1}};
    int S_TAB [4][4] = '{'{-1, -1, -1, -1}, '{3, 12, -1, -1}, '{2, 9, 11, -1}, '{1, 6, 8, 10}};

    s2_hyp_rotate_pipe #(.DWIDTH(16), .FRAC(12), .SAT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .iValid(iValid), .iReady(iReady), .iX(iX), .iY(iY),
        .iMode(iMode), .iDir(iDir), .oValid(oValid), .oReady(oReady), .oX(oX), .oY(oY), .oSat(oSat)
    );

    s2_hyp_rotate_pipe #(.DWIDTH(16), .FRAC(12), .SAT_EN(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .iValid(iValid), .iReady(iReady_w), .iX(iX), .iY(iY),
        .iMode(iMode), .iDir(iDir), .oValid(oValid_w), .oReady(oReady), .oX(oX_w), .oY(oY_w), .oSat(oSat_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // value * coefficient, where the coefficient is a sum of 2^-k terms, each term floored
    function automatic int scale(input int v, input int m, input bit sinh_sel);
        int acc = 0;
        for (int i = 0; i < 4; i++) begin
            int sh = sinh_sel ? S_TAB[m][i] : C_TAB[m][i];
            if (sh >= 0) acc += v >>> sh;
        end
        return acc;
    endfunction

    function automatic logic [32:0] ref_rot(input int x, input int y, input int m, input int d, input int sat_en);
        int xr, yr;
        bit cx, cy;
        xr = (d != 0) ? scale(x, m, 0) - scale(y, m, 1) : scale(x, m, 0) + scale(y, m, 1);
        yr = (d != 0) ? scale(y, m, 0) - scale(x, m, 1) : scale(y, m, 0) + scale(x, m, 1);
        cx = 1'b0;
        cy = 1'b0;
        if (sat_en != 0) begin
            if (xr > 32767)  begin xr = 32767;  cx = 1'b1; end
            if (xr < -32768) begin xr = -32768; cx = 1'b1; end
            if (yr > 32767)  begin yr = 32767;  cy = 1'b1; end
            if (yr < -32768) begin yr = -32768; cy = 1'b1; end
        end
        return {cx | cy, 16'(xr), 16'(yr)};
    endfunction

    task automatic cmp_out(input string tag, input logic [32:0] e, input logic [15:0] ox, input logic [15:0] oy, input logic os);
        check({tag, "_x"}, 32'($signed(ox)), 32'($signed(e[31:16])));
        check({tag, "_y"}, 32'($signed(oy)), 32'($signed(e[15:0])));
        check({tag, "_sat"}, 32'(os), 32'(e[32]));
    endtask

    // One clock cycle with scoreboard bookkeeping; sampling is mid-cycle
    task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [1:0] m,
                        input logic d, input logic ordy, output logic acc);
        logic [32:0] e;
        iValid = v; iX = x; iY = y; iMode = m; iDir = d; oReady = ordy;
        #3;
        acc = iValid && iReady;
        check("rdy_pair", 32'(iReady_w), 32'(iReady));
        check("valid_pair", 32'(oValid_w), 32'(oValid));
        if (hold_pend) begin
            check("hold_valid", 32'(oValid), 32'd1);
            check("hold_x", 32'(oX), 32'(hold_x));
            check("hold_y", 32'(oY), 32'(hold_y));
            check("hold_sat", 32'(oSat), 32'(hold_s));
        end
        if (oValid && oReady) begin
            check("sb_nonempty", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp_out("sb_sat", e, oX, oY, oSat);
                e = q0.pop_front();
                cmp_out("sb_wrap", e, oX_w, oY_w, oSat_w);
            end
        end
        hold_pend = oValid && !oReady;
        hold_x = oX; hold_y = oY; hold_s = oSat;
        if (acc) begin
            q1.push_back(ref_rot(int'($signed(x)), int'($signed(y)), int'(m), int'(d), 1));
            q0.push_back(ref_rot(int'($signed(x)), int'($signed(y)), int'(m), int'(d), 0));
        end
        @(posedge clk);
        #1;
    endtask

    // Single sample through an empty pipeline with hand-computed expectations
    task automatic directed(input string tag, input int x, input int y, input int m, input int d,
                            input int ex, input int ey, input int es,
                            input int exw, input int eyw, input int esw);
        iValid = 1'b1; iX = 16'(x); iY = 16'(y); iMode = 2'(m); iDir = 1'(d); oReady = 1'b1;
        #3;
        check({tag, "_irdy"}, 32'(iReady), 32'd1);
        @(posedge clk); #1;
        iValid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_early"}, 32'(oValid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(oValid), 32'd1);
        check({tag, "_x"}, 32'($signed(oX)), ex);
        check({tag, "_y"}, 32'($signed(oY)), ey);
        check({tag, "_sat"}, 32'(oSat), es);
        check({tag, "_wx"}, 32'($signed(oX_w)), exw);
        check({tag, "_wy"}, 32'($signed(oY_w)), eyw);
        check({tag, "_wsat"}, 32'(oSat_w), esw);
        @(posedge clk); #1;
        check({tag, "_drained"}, 32'(oValid), 32'd0);
    endtask

    initial begin
        logic acc;
        int   n_acc;
        rst_n = 1'b0; iValid = 1'b0; oReady = 1'b1; iX = 16'd0; iY = 16'd0; iMode = 2'd0; iDir = 1'b0;
        #12;
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_x", 32'(oX), 32'd0);
        check("rst_y", 32'(oY), 32'd0);
        check("rst_sat", 32'(oSat), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_irdy", 32'(iReady), 32'd1);

        directed("byp",  4096, -1000, 0, 0,  4096,  -1000, 0,  4096,  -1000, 0);
        directed("m3p",  4096, 0, 3, 0,      4616,   2132, 0,  4616,   2132, 0);
        directed("m3n",  4096, 0, 3, 1,      4616,  -2132, 0,  4616,  -2132, 0);
        directed("m2",   4096, 0, 2, 0,      4224,   1034, 0,  4224,   1034, 0);
        directed("m1",   4096, 0, 1, 0,      4128,    513, 0,  4128,    513, 0);
        directed("satp", 28672, 28672, 3, 0, 32767,  32767, 1, -18300, -18300, 0);
        directed("satn", -28672, -28672, 3, 0, -32768, -32768, 1, 18300, 18300, 0);

        // Backpressure: five offered samples against a stalled output
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'(1000 + 37 * i), 16'(-500 - 11 * i), 2'd3, 1'(i), 1'b0, acc);
            n_acc += int'(acc);
        end
        check("bp_accepts", n_acc, 3);
        check("bp_irdy_low", 32'(iReady), 32'd0);
        iValid = 1'b1; oReady = 1'b1;
        #1;
        check("fill_drain_irdy", 32'(iReady), 32'd1);
        step(1'b1, 16'd2222, 16'd333, 2'd2, 1'b0, 1'b1, acc);
        check("fill_drain_acc", 32'(acc), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b1, acc);
        check("bp_drained", 32'(q1.size()), 32'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b1, acc);
        check("rand_drained", 32'(q1.size()), 32'd0);

        // Reset with two samples in flight: outputs must clear without a clock edge
        iValid = 1'b1; iX = 16'd100; iY = 16'd7; iMode = 2'd0; iDir = 1'b0; oReady = 1'b0;
        @(posedge clk); #1;
        iX = 16'd200;
        @(posedge clk); #1;
        iValid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_x", 32'(oX), 32'd100);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(oValid), 32'd0);
        check("arst_x", 32'(oX), 32'd0);
        check("arst_y", 32'(oY), 32'd0);
        check("arst_wx", 32'(oX_w), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        q1.delete(); q0.delete(); hold_pend = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("no_stale", 32'(oValid | oValid_w), 32'd0);
            step(1'b0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b1, acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s2_hyp_rotate_pipe.md
Name: s2_hyp_rotate_pipe

Overview:
- Pipelined, parametrised successor to the stage-2 shift-add cosh scaler of the hyperbolic CORDIC.
- Applies a hyperbolic rotation of a signed fixed-point pair (x, y) by one of three fixed angles, or bypasses it:
  - x' = x·cosh(a) + d·y·sinh(a)
  - y' = y·cosh(a) + d·x·sinh(a)
  - d = +1 or -1 (direction bit).
- Multiplier-free: coefficients are sums of arithmetic-shifted terms.
- Sits between stage 1 range reduction and the CORDIC iteration core, with a valid/ready stream interface on both sides.

Parameters:
- DWIDTH, 16: data width; two's complement, signed.
- FRAC, 12: fractional bits (1.0 = 2^FRAC). Coefficient tables are fixed for FRAC=12.
- SAT_EN, 1: 1 = saturate results to DWIDTH range; 0 = wrap.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- iValid, input, 1: input sample valid.
- iReady, output, 1: block can accept a sample this cycle.
- iX, input, DWIDTH: x operand, signed.
- iY, input, DWIDTH: y operand, signed.
- iMode, input, 2: angle select. 0 = bypass, 1 = 0.125, 2 = 0.25, 3 = 0.5.
- iDir, input, 1: 0 = positive angle, 1 = negative angle (sinh terms subtracted).
- oValid, output, 1: result valid.
- oReady, input, 1: downstream accepts the result.
- oX, output, DWIDTH: rotated x'.
- oY, output, DWIDTH: rotated y'.
- oSat, output, 1: x' or y' was clipped for this sample.

Behaviour:
- Clocking and reset: single clock domain. Clock is clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - all stage valids = 0
  - oValid = 0, oX = 0, oY = 0, oSat = 0
  - iReady = 1 the cycle after reset deasserts.
- Transfer: a transfer happens on a clk edge when valid && ready.
- Pipeline: three stages, S1 to S3. Latency is exactly 3 cycles from input transfer to oValid when oReady is held at 1. Throughput is 1 sample/cycle.
- Stage advance rule: stage k loads when !valid_k or stage k+1 loads. S3 loads when !oValid or oReady.
  - iReady = S1 loads.
  - Combinational path oReady -> iReady is allowed.
  - No skid buffer.
- S1:
  - Registers x, y, mode, dir.
  - Forms the shifted terms (arithmetic right shifts, per-term truncation) for C·x, C·y, S·x, S·y from the package term tables. At most 4 terms per coefficient; unused terms are 0.
- Coefficient tables:
  - mode 0: C = 1, S = 0.
  - mode 1: C = 1 + 2^-7; S = 2^-3 + 2^-12.
  - mode 2: C = 1 + 2^-5 + 2^-13; S = 2^-2 + 2^-9 + 2^-11.
  - mode 3: C = 1 + 2^-3 + 2^-9; S = 2^-1 + 2^-6 + 2^-8 + 2^-10.
- S2: sums the terms into four partial products. Width is DWIDTH+2, so there is no internal overflow.
- S3:
  - x' = Cx ± Sy and y' = Cy ± Sx; use subtraction when dir = 1.
  - Result is DWIDTH+3 bits wide, then saturated to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1] when SAT_EN = 1, or truncated otherwise.
  - oSat = 1 if either result clipped.
- Output hold: while oValid && !oReady, oX, oY and oSat are stable. No sample is lost or duplicated, and order is preserved.
- Full pipeline: all three valids = 1 and oReady = 0 gives iReady = 0.
- Simultaneous drain and fill: when oReady = 1 with a full pipeline, iReady = 1 and a new sample enters in the same cycle.
- Reset mid-operation: in-flight samples are discarded. Outputs return to their reset values immediately, without waiting for a clock edge.
- Mode and dir are captured per sample. Changing them between transfers does not affect in-flight samples.

Decomposition:
- Package hyp_s2_pkg holds:
  - typedef for the mode enum (BYPASS, A0125, A025, A05)
  - constant term-shift tables per mode for C and S, 4 entries each, with a valid mask
  - NTERMS = 4
  - FRAC_DEFAULT = 12.
- One sub-module, hyp_shift_sum: combinational sum of up to NTERMS arithmetic-shifted copies of one operand for a selected mode. Instantiate it four times (Cx, Cy, Sx, Sy).

Test Plan:
- Reset, then mode 0, x = 4096, y = -1000, dir = 0 -> after 3 cycles oX = 4096, oY = -1000, oSat = 0.
- Mode 3, x = 4096, y = 0, dir = 0 -> oX = 4616, oY = 2132. Same with dir = 1 -> oX = 4616, oY = -2132.
- Mode 2, x = 4096, y = 0 -> oX = 4224, oY = 1034. Mode 1, x = 4096, y = 0 -> oX = 4128, oY = 513.
- Mode 3, x = y = 28672, SAT_EN = 1 -> oX = 32767, oY = 32767, oSat = 1. With SAT_EN = 0 -> wrapped values, oSat = 0.
- Backpressure: continuous iValid with distinct samples, oReady low for 5 cycles -> exactly 3 samples accepted, then iReady = 0 and oX/oY held. After oReady rises, all samples emerge in order with none lost.
- Assert rst_n low while 2 samples are in flight -> oValid = 0 and oX/oY = 0 asynchronously; no stale samples after reset release.
